// File: rtl/lut_table_loader.sv
// Loads LogicNets neuron truth tables from a config word stream into a shadow bank, then commits them to the active bank.
// Latency: lookups and readback take 1 cycle; a well-framed load commits in the cycle after its last word.
// Backpressure: cfg_ready is low only in the single commit cycle; gaps on cfg_valid simply hold the FSM.
// Optional build: define LUT_READBACK_EN to add the rb_addr/rb_data active-bank readback port.
module lut_table_loader #(
  parameter int NUM_NEURONS = 16,
  parameter int FANIN       = 6,
  parameter int WORD_W      = 16,
  localparam int TBL        = 1 << FANIN,
  localparam int NWORDS     = (NUM_NEURONS * TBL) / WORD_W,
  localparam int CNT_W      = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [WORD_W-1:0]            cfg_data,
  input  logic                         cfg_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  input  logic [NUM_NEURONS*FANIN-1:0] lut_in,
  output logic [NUM_NEURONS-1:0]       lut_out
`ifdef LUT_READBACK_EN
  ,
  input  logic [CNT_W-1:0]             rb_addr,
  output logic [WORD_W-1:0]            rb_data
`endif
);

  localparam int BANK_W  = NUM_NEURONS * TBL;
  localparam int BANK_AW = (BANK_W > 1) ? $clog2(BANK_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  // The bank must split into a whole number of config words.
  generate
    if ((BANK_W % WORD_W) != 0) begin : g_bad_word_w
      $error("lut_table_loader: NUM_NEURONS*2^FANIN must be a multiple of WORD_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   cfg_ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic [BANK_W-1:0]      shadow_q;
  logic [BANK_W-1:0]      active_q;
  logic [NUM_NEURONS-1:0] lut_out_q;

  logic                   accept;
  logic                   shadow_we;
  logic [CNT_W-1:0]       wr_word;
  logic [BANK_AW-1:0]     wr_base;
  logic [BANK_AW-1:0]     lut_idx [NUM_NEURONS];

  assign accept    = cfg_valid & cfg_ready_q;
  assign shadow_we = accept & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
  // The first word of a load is always word 0, whatever the counter holds.
  assign wr_word   = (state_q == ST_IDLE) ? '0 : cnt_q;
  assign wr_base   = BANK_AW'(wr_word) * BANK_AW'(WORD_W);

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign lut_out   = lut_out_q;

  // Load-control FSM; all status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (accept) begin
            err_q <= 1'b0;
            cnt_q <= CNT_W'(1);
            if (NWORDS == 1) begin
              if (cfg_last) begin
                state_q     <= ST_COMMIT;
                done_q      <= 1'b1;
                cfg_ready_q <= 1'b0;
              end else begin
                err_q   <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= ST_DRAIN;
              end
            end else if (cfg_last) begin
              // A one-word load is too short: flag it and stay idle.
              err_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
              if (cfg_last) begin
                state_q     <= ST_COMMIT;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                cfg_ready_q <= 1'b0;
              end else begin
                // Overlong load: swallow the tail up to its cfg_last.
                err_q   <= 1'b1;
                state_q <= ST_DRAIN;
              end
            end else if (cfg_last) begin
              // Short load: the partial shadow is never committed.
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end

        ST_DRAIN: begin
          if (accept && cfg_last) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Shadow fill from accepted words and single-cycle shadow-to-active commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (shadow_we) begin
        shadow_q[wr_base +: WORD_W] <= cfg_data;
      end
      if (state_q == ST_COMMIT) begin
        active_q <= shadow_q;
      end
    end
  end

  // Per-neuron bit address into the flat active bank.
  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      lut_idx[n] = BANK_AW'(n * TBL) + BANK_AW'(lut_in[n*FANIN +: FANIN]);
    end
  end

  // Registered lookup; in the commit cycle it still sees the old active bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lut_out_q <= '0;
    end else begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        lut_out_q[n] <= active_q[lut_idx[n]];
      end
    end
  end

`ifdef LUT_READBACK_EN
  logic [WORD_W-1:0]  rb_data_q;
  logic [BANK_AW-1:0] rb_base;

  assign rb_base = BANK_AW'(rb_addr) * BANK_AW'(WORD_W);
  assign rb_data = rb_data_q;

  // Registered word readback of the active bank, same bit order as loading.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rb_data_q <= '0;
    end else begin
      rb_data_q <= active_q[rb_base +: WORD_W];
    end
  end
`endif

endmodule
